joy_dir_conditioner: RTL and testbench

- Sits between the raw joystick comparator pins and the game logic; replaces the bare direction decode feeding game_logic.
- Synchronises and debounces the four resistor-ladder inputs, then decodes them into turn requests.
- Rejects null turns and 180° reversals, and queues up to two pending turns.
- Commits exactly one turn per game-update tick, so fast double turns are not lost.

---
 rtl/joy_dir_conditioner_pkg.sv | 28 ++
 rtl/joy_debounce.sv | 68 ++++++
 rtl/joy_dir_conditioner.sv | 119 +++++++++++
 tb/tb_joy_dir_conditioner.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/joy_dir_conditioner_pkg.sv
// Shared direction codes, request type and turn helpers for the joystick conditioner.
// The same 2-bit direction codes are used by game_logic.
package joy_dir_conditioner_pkg;

  localparam int DIR_W = 2;

  typedef logic [DIR_W-1:0] dir_t;

  localparam dir_t DIR_UP    = 2'b00;
  localparam dir_t DIR_RIGHT = 2'b01;
  localparam dir_t DIR_DOWN  = 2'b10;
  localparam dir_t DIR_LEFT  = 2'b11;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } req_t;

  function automatic dir_t reverse_dir(input dir_t d);
    return d ^ 2'b10;
  endfunction

  // A real turn is neither straight ahead nor a 180-degree reversal.
  function automatic logic is_turn(input dir_t d, input dir_t ref_dir);
    return (d != ref_dir) && (d != reverse_dir(ref_dir));
  endfunction

endpackage

// File: rtl/joy_debounce.sv
// Two-flop synchroniser for the raw stick inputs plus a stability counter on the
// decoded candidate; emits the accepted value and a one-cycle change strobe.
module joy_debounce #(
  parameter int SYNC_W = 4,
  parameter int DATA_W = 3,
  parameter int CYCLES = 250000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SYNC_W-1:0] raw,
  output logic [SYNC_W-1:0] synced,
  input  logic [DATA_W-1:0] cand,
  output logic [DATA_W-1:0] stable,
  output logic              change
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [SYNC_W-1:0] meta_reg, sync_reg;
  logic [DATA_W-1:0] prev_reg, stable_reg;
  logic [CW-1:0]     count_reg, count_next;
  logic              change_reg, accept;

  generate
    for (genvar gi = 0; gi < SYNC_W; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (reset) begin
          meta_reg[gi] <= 1'b0;
          sync_reg[gi] <= 1'b0;
        end else begin
          meta_reg[gi] <= raw[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  // count_next holds the run length of identical candidates minus one, saturating.
  always_comb begin
    count_next = '0;
    if (cand == prev_reg) begin
      count_next = (count_reg == LAST) ? count_reg : count_reg + CW'(1);
    end
    accept = (count_next == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg   <= '0;
      count_reg  <= '0;
      stable_reg <= '0;
      change_reg <= 1'b0;
    end else begin
      prev_reg   <= cand;
      count_reg  <= count_next;
      change_reg <= accept && (cand != stable_reg);
      if (accept) begin
        stable_reg <= cand;
      end
    end
  end

  assign synced = sync_reg;
  assign stable = stable_reg;
  assign change = change_reg;

endmodule

// File: rtl/joy_dir_conditioner.sv
// Joystick direction conditioner: debounced turn requests, two-entry turn queue,
// one committed turn per upd_tick. Define JOY_DBG_EN to expose dbg_req/dbg_count.
module joy_dir_conditioner
  import joy_dir_conditioner_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter logic [1:0] INIT_DIR        = 2'b01,
  parameter int         QUEUE_DEPTH     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       res_x_one,
  input  logic       res_x_two,
  input  logic       res_y_one,
  input  logic       res_y_two,
  input  logic       upd_tick,
  output logic [1:0] direction,
  output logic       turn_pending,
  output logic       turn_dropped
`ifdef JOY_DBG_EN
  ,
  output logic [2:0] dbg_req,
  output logic [1:0] dbg_count
`endif
);

  localparam logic [1:0] FULL = 2'(QUEUE_DEPTH);

  logic [3:0] sync;
  req_t       cand, stable_req;
  logic       change;

  dir_t       dir_reg;
  dir_t       q_reg [0:1];
  logic [1:0] count_reg, count_pop, count_next;
  logic       dropped_reg;

  dir_t       ref_dir, x_dir, y_dir;
  logic       x_def, y_def, pop, push, do_push, drop;

  joy_debounce #(
    .SYNC_W(4),
    .DATA_W(3),
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .reset (reset),
    .raw   ({res_x_one, res_x_two, res_y_one, res_y_two}),
    .synced(sync),
    .cand  (cand),
    .stable(stable_req),
    .change(change)
  );

  always_comb begin
    ref_dir = dir_reg;
    if (count_reg != 2'd0) begin
      ref_dir = (count_reg == FULL) ? q_reg[1] : q_reg[0];
    end

    x_def = sync[3] ^ sync[2];
    y_def = sync[1] ^ sync[0];
    x_dir = sync[3] ? DIR_RIGHT : DIR_LEFT;
    y_dir = sync[1] ? DIR_UP : DIR_DOWN;

    // On a diagonal the axis perpendicular to the current heading is the turn.
    cand = '0;
    if (x_def && (!y_def || !ref_dir[0])) begin
      cand = '{valid: 1'b1, dir: x_dir};
    end else if (y_def) begin
      cand = '{valid: 1'b1, dir: y_dir};
    end

    pop        = upd_tick && (count_reg != 2'd0);
    count_pop  = count_reg - {1'b0, pop};
    push       = change && stable_req.valid && is_turn(stable_req.dir, ref_dir);
    do_push    = push && (count_pop != FULL);
    drop       = push && !do_push;
    count_next = count_pop + {1'b0, do_push};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dir_reg     <= INIT_DIR;
      q_reg[0]    <= DIR_UP;
      q_reg[1]    <= DIR_UP;
      count_reg   <= 2'd0;
      dropped_reg <= 1'b0;
    end else begin
      if (pop) begin
        dir_reg  <= q_reg[0];
        q_reg[0] <= q_reg[1];
      end
      // Later assignment wins when the pop shift and the push hit the same slot.
      if (do_push) begin
        q_reg[count_pop[0]] <= stable_req.dir;
      end
      count_reg   <= count_next;
      dropped_reg <= drop;
    end
  end

  assign direction    = dir_reg;
  assign turn_pending = (count_reg != 2'd0);
  assign turn_dropped = dropped_reg;

`ifdef JOY_DBG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      dbg_req   <= 3'b000;
      dbg_count <= 2'd0;
    end else begin
      dbg_req   <= stable_req;
      dbg_count <= count_reg;
    end
  end
`endif

endmodule

// File: tb/tb_joy_dir_conditioner.sv
// Bench for joy_dir_conditioner: directed phases then random stick/tick traffic,
// every cycle compared against a queue-based reference model.
module tb_joy_dir_conditioner;

  localparam int DEB = 4;

  localparam logic [3:0] RAW_C  = 4'b0000;
  localparam logic [3:0] RAW_UP = 4'b0010;
  localparam logic [3:0] RAW_DN = 4'b0001;
  localparam logic [3:0] RAW_R  = 4'b1000;
  localparam logic [3:0] RAW_L  = 4'b0100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       res_x_one = 1'b0, res_x_two = 1'b0, res_y_one = 1'b0, res_y_two = 1'b0;
  logic       upd_tick = 1'b0;
  logic [1:0] direction;
  logic       turn_pending;
  logic       turn_dropped;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int drops_seen = 0;

  // Reference model state
  logic [1:0] m_dir;
  logic [1:0] m_q[$];
  logic [2:0] m_hist[$];
  logic [2:0] m_stable;
  logic       m_strobe;
  logic       m_drop;
  logic [3:0] m_sync;
  logic [3:0] m_last_raw;

  always #5 clk = ~clk;

  joy_dir_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .INIT_DIR(2'b01),
    .QUEUE_DEPTH(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .res_x_one   (res_x_one),
    .res_x_two   (res_x_two),
    .res_y_one   (res_y_one),
    .res_y_two   (res_y_two),
    .upd_tick    (upd_tick),
    .direction   (direction),
    .turn_pending(turn_pending),
    .turn_dropped(turn_dropped)
  );

  // Stick reading as signed axis values; on a diagonal, X wins when heading is vertical.
  function automatic logic [2:0] decode(input logic [3:0] raw, input logic [1:0] rd);
    int xv, yv;
    xv = int'(raw[3]) - int'(raw[2]);
    yv = int'(raw[1]) - int'(raw[0]);
    if (xv != 0 && (yv == 0 || rd == 2'b00 || rd == 2'b10))
      return {1'b1, (xv > 0) ? 2'b01 : 2'b11};
    if (yv != 0)
      return {1'b1, (yv > 0) ? 2'b00 : 2'b10};
    return 3'b000;
  endfunction

  task automatic model_edge(input logic rst, input logic [3:0] raw, input logic tick);
    logic [1:0] rd, pdir;
    logic [2:0] cand, new_stable;
    logic       legal, all_eq;
    if (rst) begin
      m_dir = 2'b01;
      m_q.delete();
      m_hist.delete();
      m_hist.push_back(3'b000);
      m_stable = 3'b000;
      m_strobe = 1'b0;
      m_drop = 1'b0;
      m_sync = 4'b0;
      m_last_raw = 4'b0;
      return;
    end
    rd = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
    cand = decode(m_sync, rd);
    m_drop = 1'b0;
    pdir = m_stable[1:0];
    legal = m_strobe && (pdir != rd) && (pdir != (rd ^ 2'b10));
    if (tick && m_q.size() > 0) m_dir = m_q.pop_front();
    if (legal) begin
      if (m_q.size() < 2) m_q.push_back(pdir);
      else m_drop = 1'b1;
    end
    m_hist.push_back(cand);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    new_stable = m_stable;
    all_eq = (m_hist.size() == DEB);
    foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) all_eq = 1'b0;
    if (all_eq) new_stable = cand;
    m_strobe = (new_stable != m_stable) && new_stable[2];
    m_stable = new_stable;
    m_sync = m_last_raw;
    m_last_raw = raw;
  endtask

  task automatic check_outputs();
    checks++;
    assert (direction === m_dir) else begin
      failures++;
      $error("FAIL direction cyc=%0d got=%0d exp=%0d", cyc, direction, m_dir);
    end
    checks++;
    assert (turn_pending === (m_q.size() > 0)) else begin
      failures++;
      $error("FAIL turn_pending cyc=%0d got=%0b exp=%0b", cyc, turn_pending, m_q.size() > 0);
    end
    checks++;
    assert (turn_dropped === m_drop) else begin
      failures++;
      $error("FAIL turn_dropped cyc=%0d got=%0b exp=%0b", cyc, turn_dropped, m_drop);
    end
    if (m_drop) drops_seen++;
  endtask

  task automatic step(input logic [3:0] raw, input logic tick, input logic rst);
    @(negedge clk);
    {res_x_one, res_x_two, res_y_one, res_y_two} = raw;
    upd_tick = tick;
    reset = rst;
    @(posedge clk);
    model_edge(rst, raw, tick);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic hold(input logic [3:0] raw, input int n);
    for (int i = 0; i < n; i++) step(raw, 1'b0, 1'b0);
  endtask

  task automatic tick_once(input logic [3:0] raw);
    step(raw, 1'b1, 1'b0);
  endtask

  initial begin
    int n;
    logic [3:0] r;

    // Reset and reset-state check
    step(RAW_C, 1'b0, 1'b1);
    step(RAW_C, 1'b1, 1'b1);
    checks++;
    assert (direction === 2'b01 && turn_pending === 1'b0 && turn_dropped === 1'b0) else begin
      failures++;
      $error("FAIL reset_state got=%0d/%0b/%0b exp=1/0/0", direction, turn_pending, turn_dropped);
    end
    $display("phase reset done cyc=%0d", cyc);

    // UP held, then a tick commits it
    hold(RAW_UP, 10);
    tick_once(RAW_C);
    hold(RAW_C, 6);
    $display("phase up_turn cyc=%0d dir=%0d", cyc, direction);

    // Back to RIGHT, then LEFT is a reversal and must be ignored
    hold(RAW_R, 8);
    tick_once(RAW_C);
    hold(RAW_C, 6);
    hold(RAW_L, 8);
    tick_once(RAW_C);
    tick_once(RAW_C);
    hold(RAW_C, 6);
    $display("phase reverse_reject cyc=%0d dir=%0d", cyc, direction);

    // Two queued turns, popped one per tick
    hold(RAW_UP, 6); hold(RAW_C, 6); hold(RAW_L, 6); hold(RAW_C, 4);
    tick_once(RAW_C); hold(RAW_C, 2);
    tick_once(RAW_C); hold(RAW_C, 2);
    $display("phase double_turn cyc=%0d dir=%0d", cyc, direction);

    // Overfill: queue full, extra valid turn dropped
    hold(RAW_UP, 6); hold(RAW_C, 6); hold(RAW_R, 6); hold(RAW_C, 6);
    hold(RAW_DN, 6); hold(RAW_C, 6); hold(RAW_UP, 6); hold(RAW_L, 6); hold(RAW_UP, 6);
    hold(RAW_C, 6);
    tick_once(RAW_C); tick_once(RAW_C); tick_once(RAW_C);
    $display("phase overfill cyc=%0d drops=%0d", cyc, drops_seen);

    // Bouncing input never settles
    for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? RAW_DN : RAW_C, 2);
    hold(RAW_C, 6);
    $display("phase bounce cyc=%0d pending=%0b", cyc, turn_pending);

    // Queue two turns, then reset together with a tick
    hold(RAW_DN, 6); hold(RAW_C, 6); hold(RAW_R, 6); hold(RAW_C, 4);
    step(RAW_C, 1'b1, 1'b1);
    hold(RAW_C, 3);
    $display("phase reset_with_tick cyc=%0d dir=%0d", cyc, direction);

    // Random traffic including diagonals, simultaneous push/pop and rare resets
    for (int t = 0; t < 300; t++) begin
      r = 4'($urandom_range(0, 15));
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++)
        step(r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 399) == 0));
    end
    $display("phase random cyc=%0d drops=%0d", cyc, drops_seen);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
